// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART TX byte port
// between several valid/ready byte streams, with a registered output slot.
module uart_tx_arbiter #(
  parameter  int REQUESTERS   = 2,
  parameter  int MAX_BURST    = 64,
  parameter  int IDLE_TIMEOUT = 1024,
  localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [REQUESTERS-1:0]   req_valid_i,
  input  logic [8*REQUESTERS-1:0] req_data_i,
  input  logic [REQUESTERS-1:0]   req_last_i,
  output logic [REQUESTERS-1:0]   req_ready_o,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic                    grant_valid_o,
  output logic [IW-1:0]           grant_id_o
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] IDLE_END  = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] last_grant;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] idle_cnt;
  logic          slot_free;
  logic          own_valid;
  logic          own_last;
  logic [7:0]    own_data;
  logic          accept;
  logic          found;
  logic [IW-1:0] winner;

  assign slot_free = !tx_valid_o || tx_ready_i;
  assign accept    = (state == GRANT) && slot_free && own_valid;

  always_comb begin
    own_valid   = 1'b0;
    own_last    = 1'b0;
    own_data    = 8'h00;
    req_ready_o = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (grant_id_o == IW'(k)) begin
        own_valid      = req_valid_i[k];
        own_last       = req_last_i[k];
        own_data       = req_data_i[8*k +: 8];
        req_ready_o[k] = (state == GRANT) && slot_free;
      end
    end
  end

  // Scan starts just after the previous owner so every port gets a turn.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      tx_valid_o    <= 1'b0;
      tx_data_o     <= 8'h00;
      grant_valid_o <= 1'b0;
      grant_id_o    <= '0;
      last_grant    <= IW'(REQUESTERS - 1);
      burst_cnt     <= '0;
      idle_cnt      <= '0;
    end else begin
      if (accept) begin
        tx_data_o  <= own_data;
        tx_valid_o <= 1'b1;
      end else if (tx_ready_i) begin
        tx_valid_o <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (found) begin
            state         <= GRANT;
            grant_id_o    <= winner;
            grant_valid_o <= 1'b1;
            burst_cnt     <= '0;
            idle_cnt      <= '0;
          end
        end
        GRANT: begin
          if (accept) begin
            burst_cnt <= burst_cnt + BW'(1);
            idle_cnt  <= '0;
            if (own_last || burst_cnt == BURST_END) begin
              state         <= IDLE;
              grant_valid_o <= 1'b0;
              last_grant    <= grant_id_o;
            end
          end else if (!own_valid) begin
            if (idle_cnt == IDLE_END) begin
              state         <= IDLE;
              grant_valid_o <= 1'b0;
              last_grant    <= grant_id_o;
            end else begin
              idle_cnt <= idle_cnt + TW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed messages, queued expected
// bytes and grant order, checked by a monitor on each TX handshake.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        grant_valid;
  logic [0:0]  grant_id;

  int pass_cnt = 0;
  int total    = 0;

  logic [8:0] rq0[$];
  logic [8:0] rq1[$];
  logic [7:0] exp_b[$];
  logic [0:0] exp_g[$];
  logic [1:0] acc;
  logic       prev_gv;

  uart_tx_arbiter #(
    .REQUESTERS(2),
    .MAX_BURST(4),
    .IDLE_TIMEOUT(8)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .req_valid_i(req_valid),
    .req_data_i(req_data),
    .req_last_i(req_last),
    .req_ready_o(req_ready),
    .tx_data_o(tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .grant_valid_o(grant_valid),
    .grant_id_o(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive();
    req_valid[0] = (rq0.size() > 0);
    req_valid[1] = (rq1.size() > 0);
    {req_last[0], req_data[7:0]}  = (rq0.size() > 0) ? rq0[0] : 9'h000;
    {req_last[1], req_data[15:8]} = (rq1.size() > 0) ? rq1[0] : 9'h000;
  endtask

  // Requester models: present queue head, pop on a sampled handshake.
  initial begin
    acc = 2'b00;
    drive();
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready & {2{rst_n}};
      @(posedge clk);
      #2;
      if (acc[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (acc[1] && rq1.size() > 0) void'(rq1.pop_front());
      drive();
    end
  end

  // Monitor: TX handshakes and new grants against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gv = 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        if (exp_b.size() == 0) begin
          total++;
          $display("FAIL tx_extra: got byte %0h expected none", tx_data);
        end else begin
          chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_b.pop_front()});
        end
      end
      if (grant_valid && !prev_gv) begin
        if (exp_g.size() == 0) begin
          total++;
          $display("FAIL grant_extra: got id %0d expected none", grant_id);
        end else begin
          chk("grant_id", {31'h0, grant_id}, {31'h0, exp_g.pop_front()});
        end
      end
      prev_gv = grant_valid;
    end
  end

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_b.size() == 0 && exp_g.size() == 0 && rq0.size() == 0 &&
          rq1.size() == 0 && !grant_valid && !tx_valid)
        done = 1;
    end
    if (!done) begin
      total++;
      $display("FAIL %s_idle: got %0d bytes %0d grants pending expected 0",
               nm, exp_b.size(), exp_g.size());
    end
  endtask

  task automatic wait_grant(input logic [0:0] id, input string nm);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (grant_valid && grant_id == id) done = 1;
    end
    if (!done) begin
      total++;
      $display("FAIL %s_grant_wait: got none expected grant %0d", nm, id);
    end
  endtask

  task automatic wait_txv(input string nm);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (tx_valid) done = 1;
    end
    if (!done) begin
      total++;
      $display("FAIL %s_txv_wait: got tx_valid 0 expected 1", nm);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", {31'h0, tx_valid}, 0);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_grant_valid", {31'h0, grant_valid}, 0);
    chk("rst_grant_id", {31'h0, grant_id}, 0);
    chk("rst_req_ready", {30'h0, req_ready}, 0);
    rst_n = 1'b1;

    // Single message with cycle-exact timing
    @(posedge clk); #1;
    rq0.push_back({1'b0, 8'h48});
    rq0.push_back({1'b1, 8'h69});
    exp_b.push_back(8'h48);
    exp_b.push_back(8'h69);
    exp_g.push_back(1'b0);
    @(negedge clk);
    chk("t1_arb_bubble", {31'h0, grant_valid}, 0);
    @(negedge clk);
    chk("t1_grant", {31'h0, grant_valid}, 1);
    chk("t1_gid", {31'h0, grant_id}, 0);
    chk("t1_txv0", {31'h0, tx_valid}, 0);
    chk("t1_ready", {30'h0, req_ready}, 2'b01);
    @(negedge clk);
    chk("t1_b0_valid", {31'h0, tx_valid}, 1);
    chk("t1_b0_data", {24'h0, tx_data}, 8'h48);
    @(negedge clk);
    chk("t1_b1_data", {24'h0, tx_data}, 8'h69);
    chk("t1_release", {31'h0, grant_valid}, 0);
    wait_idle("t1");

    // Round robin, one-byte messages from both ports
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      rq0.push_back({1'b1, 8'hA0 + 8'(i)});
      rq1.push_back({1'b1, 8'hB0 + 8'(i)});
      exp_b.push_back(8'hA0 + 8'(i));
      exp_b.push_back(8'hB0 + 8'(i));
      exp_g.push_back(1'b0);
      exp_g.push_back(1'b1);
    end
    wait_idle("t2");

    // Backpressure mid-message
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rq0.push_back({i == 3, 8'hC0 + 8'(i)});
      exp_b.push_back(8'hC0 + 8'(i));
    end
    exp_g.push_back(1'b0);
    wait_txv("t3");
    chk("t3_first", {24'h0, tx_data}, 8'hC0);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_data", {24'h0, tx_data}, 8'hC1);
      chk("t3_ready_low", {30'h0, req_ready}, 2'b00);
      chk("t3_keep_grant", {31'h0, grant_valid}, 1);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_idle("t3");

    // Burst limit: 4 bytes then the grant moves on
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) rq0.push_back({1'b0, 8'hD0 + 8'(i)});
    for (int i = 0; i < 4; i++) exp_b.push_back(8'hD0 + 8'(i));
    exp_b.push_back(8'hE0);
    exp_b.push_back(8'hE1);
    for (int i = 4; i < 10; i++) exp_b.push_back(8'hD0 + 8'(i));
    exp_g.push_back(1'b0);
    exp_g.push_back(1'b1);
    exp_g.push_back(1'b0);
    exp_g.push_back(1'b0);
    wait_grant(1'b0, "t4");
    @(posedge clk); #1;
    rq1.push_back({1'b0, 8'hE0});
    rq1.push_back({1'b1, 8'hE1});
    wait_idle("t4");

    // Idle timeout: eight idle cycles then the other port
    @(posedge clk); #1;
    rq0.push_back({1'b0, 8'hF0});
    exp_b.push_back(8'hF0);
    exp_b.push_back(8'h5A);
    exp_g.push_back(1'b0);
    exp_g.push_back(1'b1);
    wait_grant(1'b0, "t5");
    @(posedge clk); #1;
    rq1.push_back({1'b1, 8'h5A});
    @(negedge clk);
    chk("t5_f0_valid", {31'h0, tx_valid}, 1);
    chk("t5_f0_data", {24'h0, tx_data}, 8'hF0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t5_still_owned", {31'h0, grant_valid}, 1);
    end
    @(negedge clk);
    chk("t5_timeout", {31'h0, grant_valid}, 0);
    @(negedge clk);
    chk("t5_next_grant", {31'h0, grant_valid}, 1);
    chk("t5_next_id", {31'h0, grant_id}, 1);
    wait_idle("t5");

    // Reset with a byte held in the output slot
    @(posedge clk); #1;
    tx_ready = 1'b0;
    rq1.push_back({1'b0, 8'h70});
    rq1.push_back({1'b0, 8'h71});
    rq1.push_back({1'b1, 8'h72});
    exp_g.push_back(1'b1);
    wait_txv("t6");
    #3;
    rst_n = 1'b0;
    rq0.delete();
    rq1.delete();
    #1;
    chk("t6_tx_valid", {31'h0, tx_valid}, 0);
    chk("t6_tx_data", {24'h0, tx_data}, 0);
    chk("t6_grant_valid", {31'h0, grant_valid}, 0);
    chk("t6_grant_id", {31'h0, grant_id}, 0);
    chk("t6_req_ready", {30'h0, req_ready}, 0);
    repeat (2) @(negedge clk);
    tx_ready = 1'b1;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    rq0.push_back({1'b1, 8'h11});
    rq1.push_back({1'b1, 8'h22});
    exp_b.push_back(8'h11);
    exp_b.push_back(8'h22);
    exp_g.push_back(1'b0);
    exp_g.push_back(1'b1);
    wait_idle("t6");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single board UART transmitter between several byte-stream requesters, e.g. the CPU console port and the debug/monitor port. Arbitration is round-robin at message granularity: a granted requester keeps the transmitter until it marks a byte as last, hits the burst limit, or goes idle too long. It sits between the requesters' valid/ready byte streams and the UART TX byte interface. It holds one registered output byte so the TX side sees registered data and valid.

Parameters:
REQUESTERS, 2, number of requester ports (2..8)
MAX_BURST, 64, maximum bytes accepted in one grant before forced release (1..255)
IDLE_TIMEOUT, 1024, cycles the owner may hold valid low while granted before forced release (1..65535)

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  asynchronous, active-low reset
req_valid_i  in  REQUESTERS  per-requester byte valid
req_data_i  in  8*REQUESTERS  per-requester byte; requester k uses bits [8k+7:8k]
req_last_i  in  REQUESTERS  byte is the final byte of a message
req_ready_o  out  REQUESTERS  per-requester byte accepted (valid&ready)
tx_data_o  out  8  byte to UART transmitter
tx_valid_o  out  1  tx_data_o holds an untransmitted byte
tx_ready_i  in  1  UART transmitter accepts tx_data_o this cycle
grant_valid_o  out  1  a requester currently owns the transmitter
grant_id_o  out  $clog2(REQUESTERS) (min 1)  index of the current owner

Behaviour:
- Reset (async assert, sync deassert usage): state=IDLE; tx_valid_o=0; tx_data_o=8'h00; grant_valid_o=0; grant_id_o=0; req_ready_o=0; rr pointer last_grant=REQUESTERS-1 so requester 0 wins first; burst and idle counters=0. Reset mid-message drops any held byte with no partial transmission.
- Output register: slot_free = !tx_valid_o | tx_ready_i. When tx_valid_o & tx_ready_i and no new byte is loaded, tx_valid_o goes to 0 next cycle. A simultaneous drain and load keeps tx_valid_o=1 with the new data, giving full throughput.
- req_ready_o is combinational: bit owner = (state==GRANT) & slot_free; all other bits are 0. req_ready_o never depends on req_valid_i of the same port.
- FSM IDLE: if any req_valid_i, winner = first set bit scanning last_grant+1, +2, … with wrap modulo REQUESTERS. On that edge: state<=GRANT, grant_id_o<=winner, grant_valid_o<=1, counters<=0. No byte is accepted in IDLE, so arbitration costs one cycle.
- FSM GRANT:
  - Accept when req_valid_i[owner] & req_ready_o[owner]. Load tx_data_o<=req_data_i[owner], set tx_valid_o<=1, burst_cnt++, and clear idle_cnt.
  - Release when the accepted byte has req_last_i=1, or burst_cnt reaches MAX_BURST on this accept. On release: state<=IDLE, grant_valid_o<=0, last_grant<=owner.
  - If req_valid_i[owner]=0, idle_cnt++. When idle_cnt reaches IDLE_TIMEOUT-1 with valid still low, release the same way.
  - Valid high but stalled by a full slot does not count as idle.
- Release does not wait for the output slot to drain. The next owner's first byte is loaded only once slot_free.
- Other requesters' valid bits are ignored while GRANT. Requesters may hold valid indefinitely; no byte is lost or duplicated.
- Counters are sized to hold MAX_BURST and IDLE_TIMEOUT exactly; no wrap-around occurs because release happens at the limit.
- REQUESTERS=1 degenerates to pass-through plus the one-cycle IDLE bubble per message.

Test Plan:
- Reset then single message: req0 sends 8'h48,8'h69 (last on 8'h69), tx_ready_i=1 → grant at cycle 1, tx_data_o 8'h48 then 8'h69 on consecutive cycles, grant_valid_o=0 after 8'h69 is accepted.
- Round-robin contention, REQUESTERS=2: both valid continuously with 1-byte messages (last=1) → grant_id_o alternates 0,1,0,1 and tx byte order interleaves the streams exactly.
- Backpressure: tx_ready_i=0 for 10 cycles mid-message → req_ready_o[owner]=0 after the slot fills, tx_data_o stable, idle_cnt not incrementing, no byte lost when tx_ready_i returns to 1.
- Burst limit with MAX_BURST=4: req0 streams 10 bytes, never last, while req1 is valid → after 4 bytes grant passes to req1, and req0 resumes at byte 5 after req1's message.
- Idle timeout with IDLE_TIMEOUT=8: req0 sends 1 byte without last then drops valid → release after 8 idle cycles, and req1 is granted on the following cycle.
- Reset mid-message: assert reset_n_i=0 with tx_valid_o=1 → all outputs return to reset values immediately (asynchronously), and requester 0 wins first after reset is released.
